// File: rtl/adder_pkg.sv
// Shared constants, stage control record and chunk-width helper for the pipelined ripple-carry adder.
package adder_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_STAGES = 4;

    // Per-stage control record; the data fields are sized per stage inside the top.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctrl_t;

    function automatic int chunk_w(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational W-bit ripple-carry adder built from one-bit full-adder cells.
module rca_chunk
    import adder_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[W];

endmodule

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder: one CHUNK-bit ripple add per stage, carry registered between stages.
// Optional signed-overflow output enabled by defining ADDER_OVF_FLAG_EN.
module pipelined_rca_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADDER_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int CHUNK = chunk_w(WIDTH, STAGES);

    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipelined_rca_adder: WIDTH must be a positive multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    // Global stall: every stage shifts together only when the output slot is free or being drained.
    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int INW = WIDTH - k * CHUNK;   // operand bits not yet consumed on entry
        localparam int REM = INW - CHUNK;         // operand bits forwarded to later stages

        logic [INW-1:0]         in_a;
        logic [INW-1:0]         in_b;
        logic                   ci;
        logic                   vin;
        logic [CHUNK-1:0]       op_a;
        logic [CHUNK-1:0]       op_b;
        logic [CHUNK-1:0]       s;
        logic                   co;
        logic [(k+1)*CHUNK-1:0] sum_d;
        logic [(k+1)*CHUNK-1:0] sum_q;
        stage_ctrl_t            ctrl_q;

        if (k == 0) begin : g_src
            assign in_a  = a;
            assign in_b  = b;
            assign ci    = cin;
            assign vin   = in_valid;
            assign sum_d = s;
        end else begin : g_src
            assign in_a  = g_stage[k-1].g_fwd.a_q;
            assign in_b  = g_stage[k-1].g_fwd.b_q;
            assign ci    = g_stage[k-1].ctrl_q.carry;
            assign vin   = g_stage[k-1].ctrl_q.valid;
            assign sum_d = {s, g_stage[k-1].sum_q};
        end

        assign op_a = in_a[CHUNK-1:0];
        assign op_b = in_b[CHUNK-1:0];

        rca_chunk #(.W(CHUNK)) u_rca (
            .a  (op_a),
            .b  (op_b),
            .ci (ci),
            .s  (s),
            .co (co)
        );

        // NOTE: datapath registers are reset too, so sum/cout read 0 straight after reset.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ctrl_q <= '0;
                sum_q  <= '0;
            end else if (advance) begin
                ctrl_q <= '{valid: vin, carry: co};
                sum_q  <= sum_d;
            end
        end

        if (REM > 0) begin : g_fwd
            logic [REM-1:0] a_q;
            logic [REM-1:0] b_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= in_a[INW-1:CHUNK];
                    b_q <= in_b[INW-1:CHUNK];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].ctrl_q.valid;
    assign cout      = g_stage[STAGES-1].ctrl_q.carry;
    assign sum       = g_stage[STAGES-1].sum_q;

`ifdef ADDER_OVF_FLAG_EN
    // The sign bits of both operands arrive with the last chunk, so ovf is formed there.
    logic sign_a;
    logic sign_b;
    logic sign_s;
    logic ovf_d;

    assign sign_a = g_stage[STAGES-1].op_a[CHUNK-1];
    assign sign_b = g_stage[STAGES-1].op_b[CHUNK-1];
    assign sign_s = g_stage[STAGES-1].s[CHUNK-1];
    assign ovf_d  = (sign_a == sign_b) && (sign_s != sign_a);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (advance) begin
            ovf <= ovf_d;
        end
    end
`endif

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Self-checking bench for pipelined_rca_adder: randomized traffic scored against an arithmetic model.
// Define ADDER_OVF_FLAG_EN to also exercise the overflow flag; override STAGES to sweep pipeline depth.
module tb_pipelined_rca_adder #(
    parameter int STAGES = 4
);

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef ADDER_OVF_FLAG_EN
    logic             ovf;
`endif

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    logic out_fired = 1'b0;

    pipelined_rca_adder #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef ADDER_OVF_FLAG_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
        exp_t           e;
        logic [WIDTH:0] t;
        t      = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
        e.sum  = t[WIDTH-1:0];
        e.cout = t[WIDTH];
        e.ovf  = (x[WIDTH-1] == y[WIDTH-1]) && (e.sum[WIDTH-1] != x[WIDTH-1]);
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] rnd();
        case ($urandom_range(0, 5))
            0:       return '1;
            1:       return '0;
            default: return WIDTH'($urandom());
        endcase
    endfunction

    // One clock: drive at the falling edge, score what the next rising edge consumes and accepts.
    task automatic step(input logic v, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic c, input logic ordy);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        a         = av;
        b         = bv;
        cin       = c;
        out_ready = ordy;
        #1;
        out_fired = out_valid && out_ready;
        if (out_fired) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_result: got sum=%h cout=%b, required no result", sum, cout);
            end else begin
                e = exp_q.pop_front();
                if (sum !== e.sum || cout !== e.cout) begin
                    n_errors++;
                    $display("FAIL result: got sum=%h cout=%b, required sum=%h cout=%b", sum, cout, e.sum, e.cout);
                end
`ifdef ADDER_OVF_FLAG_EN
                n_checks++;
                if (ovf !== e.ovf) begin
                    n_errors++;
                    $display("FAIL result_ovf: got ovf=%b, required ovf=%b (sum=%h)", ovf, e.ovf, e.sum);
                end
`endif
            end
        end
        if (in_valid && in_ready) exp_q.push_back(model(av, bv, c));
    endtask

    task automatic idle_step();
        step(1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < STAGES + 8) begin
            idle_step();
            guard++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < STAGES + 1; i++) step(1'b1, rnd(), rnd(), 1'($urandom_range(0, 1)), 1'b0);
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_out_valid: got %b, required 0", out_valid);
        end
        n_checks++;
        if (sum !== '0 || cout !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_sum_cout: got sum=%h cout=%b, required 0/0", sum, cout);
        end
`ifdef ADDER_OVF_FLAG_EN
        n_checks++;
        if (ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ovf: got %b, required 0", ovf);
        end
`endif
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    // Single op into an empty pipe: checks latency and the result against fixed expected values.
    task automatic test_directed(input string name, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic c, input logic [WIDTH-1:0] exp_sum, input logic exp_cout,
                                 input logic exp_ovf);
        int lat = -1;
        drain();
        step(1'b1, av, bv, c, 1'b1);
        for (int i = 1; i <= STAGES + 4; i++) begin
            idle_step();
            if (out_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
        n_checks++;
        if (lat != STAGES) begin
            n_errors++;
            $display("FAIL %s_latency: got %0d clks (-1 = none), required %0d", name, lat, STAGES);
        end
        if (lat > 0) begin
            n_checks++;
            if (sum !== exp_sum || cout !== exp_cout) begin
                n_errors++;
                $display("FAIL %s_value: got sum=%h cout=%b, required sum=%h cout=%b",
                         name, sum, cout, exp_sum, exp_cout);
            end
`ifdef ADDER_OVF_FLAG_EN
            n_checks++;
            if (ovf !== exp_ovf) begin
                n_errors++;
                $display("FAIL %s_ovf: got %b, required %b", name, ovf, exp_ovf);
            end
`else
            if (exp_ovf === 1'bx) $display("%s: overflow flag not built", name);
`endif
        end
    endtask

    task automatic test_streaming();
        int cyc   = 0;
        int first = -1;
        int last  = -1;
        int total = 0;
        drain();
        for (int i = 0; i < 8 + STAGES + 4; i++) begin
            if (i == 3) step(1'b1, 32'h1234_5678, 32'h8765_4321, 1'b1, 1'b1);
            else if (i < 8) step(1'b1, rnd(), rnd(), 1'($urandom_range(0, 1)), 1'b1);
            else idle_step();
            if (out_fired) begin
                if (first < 0) first = cyc;
                last = cyc;
                total++;
            end
            cyc++;
        end
        n_checks++;
        if (total != 8 || last - first != 7) begin
            n_errors++;
            $display("FAIL streaming_rate: got %0d results over %0d cycles, required 8 over 8", total, last - first + 1);
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] held_sum;
        logic             held_cout;
        drain();
        for (int i = 0; i < STAGES + 3; i++) step(1'b1, rnd(), rnd(), 1'($urandom_range(0, 1)), 1'b0);
        held_sum  = sum;
        held_cout = cout;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, rnd(), rnd(), 1'($urandom_range(0, 1)), 1'b0);
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL stall_handshake: got in_ready=%b out_valid=%b, required 0/1", in_ready, out_valid);
            end
            n_checks++;
            if (sum !== held_sum || cout !== held_cout) begin
                n_errors++;
                $display("FAIL stall_hold: got sum=%h cout=%b, required sum=%h cout=%b", sum, cout, held_sum, held_cout);
            end
        end
        for (int i = 0; i < 4; i++) step(1'b1, rnd(), rnd(), 1'($urandom_range(0, 1)), 1'b1);
        drain();
    endtask

    task automatic test_mid_reset();
        int seen = 0;
        drain();
        for (int i = 0; i < 3; i++) step(1'b1, rnd(), rnd(), 1'($urandom_range(0, 1)), 1'b1);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < STAGES + 3; i++) begin
            idle_step();
            if (out_valid !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_errors++;
            $display("FAIL mid_reset_flush: got out_valid on %0d cycles, required 0", seen);
        end
        test_directed("post_reset", 32'h0000_00FF, 32'h0000_0F01, 1'b0, 32'h0000_1000, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        drain();
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 9) < 7), rnd(), rnd(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 9) < 6));
        end
        drain();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        test_reset();
        test_directed("carry_chain", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        test_directed("mixed", 32'h1234_5678, 32'h8765_4321, 1'b1, 32'h9999_999A, 1'b0, 1'b0);
        test_streaming();
        test_backpressure();
        test_mid_reset();
`ifdef ADDER_OVF_FLAG_EN
        test_directed("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        test_directed("ovf_neg", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        test_directed("ovf_min", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
`endif
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
